uart_rx_port: RTL

- Serial receive stage for the Micro80 I/O space, companion to the existing E8/E9 transmitter.
- 16x-oversampled UART receiver feeding an RX FIFO; the CPU reads it through I/O ports 0xE8 (data) and 0xE9 (status).
- Its DOUT/DOUT_EN outputs feed the top-level IO read mux (IO_DO path to CPU_DI).

---
 rtl/uart_rx_port.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_port.sv
`default_nettype none
// =============================================================================
// uart_rx_port : 16x-oversampled UART receiver + RX FIFO on I/O ports E8/E9.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit check.   Rev 1.0
// =============================================================================
module uart_rx_port #(
  parameter int unsigned CLK_HZ     = 20000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [7:0]  PORT_DATA  = 8'hE8,
  parameter logic [7:0]  PORT_STAT  = 8'hE9
) (
  input  logic       CLK20,
  input  logic       CRST,
  input  logic       RX,
  input  logic [7:0] ADDR,
  input  logic       IORD,
  input  logic       TX_BSY,
  output logic [7:0] DOUT,
  output logic       DOUT_EN,
  output logic       RXRDY
);

  localparam int unsigned DIV   = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int unsigned DIV_W = ($clog2(DIV) > 0) ? $clog2(DIV) : 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic iord_s1_q, iord_s2_q, iord_prev_q;

  always_ff @(posedge CLK20 or negedge CRST) begin
    if (!CRST) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      iord_s1_q   <= 1'b1;
      iord_s2_q   <= 1'b1;
      iord_prev_q <= 1'b1;
    end else begin
      rx_s1_q     <= RX;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      iord_s1_q   <= IORD;
      iord_s2_q   <= iord_s1_q;
      iord_prev_q <= iord_s2_q;
    end
  end

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       samp_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             brk_q;
  logic             push_q;
  logic             ferr_set_q;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  // Held at zero while idle so the first tick lands a fixed time after the start edge
  always_ff @(posedge CLK20 or negedge CRST) begin
    if (!CRST)                  div_q <= '0;
    else if (state_q == S_IDLE) div_q <= '0;
    else if (tick)              div_q <= '0;
    else                        div_q <= div_q + DIV_W'(1);
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, perr_set_q, perr_q;
`endif

  always_ff @(posedge CLK20 or negedge CRST) begin
    if (!CRST) begin
      state_q    <= S_IDLE;
      samp_q     <= 4'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      brk_q      <= 1'b0;
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      perr_set_q <= 1'b0;
`endif
    end else begin
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_set_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            state_q <= S_START;
            samp_q  <= 4'd0;
          end
        end
        S_START: begin
          if (tick) begin
            if (samp_q == 4'd7) begin
              samp_q <= 4'd0;
              bit_q  <= 3'd0;
              state_q <= rx_s2_q ? S_IDLE : S_DATA;
            end else begin
              samp_q <= samp_q + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            samp_q <= samp_q + 4'd1;
            if (samp_q == 4'd15) begin
              shift_q <= {rx_s2_q, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q   <= S_PAR;
                par_bad_q <= 1'b0;
`else
                state_q   <= S_STOP;
`endif
                brk_q     <= 1'b0;
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: begin
          if (tick) begin
            samp_q <= samp_q + 4'd1;
            if (samp_q == 4'd15) begin
              if ((^shift_q) ^ rx_s2_q) begin
                par_bad_q  <= 1'b1;
                perr_set_q <= 1'b1;
              end
              state_q <= S_STOP;
            end
          end
        end
`endif
        S_STOP: begin
          if (brk_q) begin
            if (rx_s2_q) begin
              brk_q   <= 1'b0;
              state_q <= S_IDLE;
            end
          end else if (tick) begin
            samp_q <= samp_q + 4'd1;
            if (samp_q == 4'd15) begin
              if (rx_s2_q) begin
`ifdef UART_RX_PARITY_EN
                push_q <= !par_bad_q;
`else
                push_q <= 1'b1;
`endif
                state_q <= S_IDLE;
              end else begin
                ferr_set_q <= 1'b1;
                brk_q      <= 1'b1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_q, rd_q;
  logic [DEPTH_LOG2:0]   cnt_q;
  logic                  ovr_q, ferr_q;
  logic                  full, empty, rd_edge, pop, push_ok, ovr_set, stat_clr, perr;
  logic [7:0]            stat;

  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign rd_edge  = iord_s2_q && !iord_prev_q;
  assign pop      = rd_edge && (ADDR == PORT_DATA) && !empty;
  assign push_ok  = push_q && (!full || pop);
  assign ovr_set  = push_q && full && !pop;
  assign stat_clr = rd_edge && (ADDR == PORT_STAT);
`ifdef UART_RX_PARITY_EN
  assign perr     = perr_q;
`else
  assign perr     = 1'b0;
`endif
  assign stat     = {2'b00, perr, full, ferr_q, ovr_q, TX_BSY, !empty};
  assign RXRDY    = !empty;

  always_ff @(posedge CLK20) begin
    if (push_ok) mem_q[wr_q] <= shift_q;
  end

  // Error flags: a set arriving with a status-read clear takes priority
  always_ff @(posedge CLK20 or negedge CRST) begin
    if (!CRST) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (ovr_set)         ovr_q  <= 1'b1;
      else if (stat_clr)   ovr_q  <= 1'b0;
      if (ferr_set_q)      ferr_q <= 1'b1;
      else if (stat_clr)   ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (perr_set_q)      perr_q <= 1'b1;
      else if (stat_clr)   perr_q <= 1'b0;
`endif
    end
  end

  always_comb begin
    DOUT    = 8'h00;
    DOUT_EN = 1'b0;
    if (!iord_s2_q) begin
      if (ADDR == PORT_DATA) begin
        DOUT_EN = 1'b1;
        DOUT    = empty ? 8'h00 : mem_q[rd_q];
      end else if (ADDR == PORT_STAT) begin
        DOUT_EN = 1'b1;
        DOUT    = stat;
      end
    end
  end

endmodule
`default_nettype wire
